// File: rtl/rs_enc_if.sv
// Symbol stream bundle between the RS encoder and its neighbours.
// The slave view is the encoder; the master view feeds and drains it.
interface rs_enc_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic       out_sop;
    logic       out_eop;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sop,
        input  out_eop
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sop,
        output out_eop
    );
endinterface

// File: rtl/rs_enc.sv
// Systematic RS(N,K) encoder over GF(2^10), poly 0x409, 30 parity symbols.
// Define RS_ENC_CW_CNT_EN to add the 16-bit cw_cnt codeword counter port.
module rs_enc #(
    parameter int N = 544,
    parameter int K = 514
) (
    input  logic       clk,
    input  logic       rst_n,
    rs_enc_if.slave    bus
`ifdef RS_ENC_CW_CNT_EN
    ,
    output logic [15:0] cw_cnt
`endif
);

    localparam int P = N - K;

    typedef enum logic {
        MSG,
        PAR
    } state_t;

    function automatic logic [9:0] gf_mul(
        input logic [9:0] a,
        input logic [9:0] b
    );
        logic [9:0] r;
        logic [9:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[8:0], 1'b0} ^ (x[9] ? 10'h009 : 10'h000);
        end
        return r;
    endfunction

    // g(x) = prod (x + alpha^i); the monic x^P term is implicit.
    function automatic logic [P-1:0][9:0] gen_poly();
        logic [P:0][9:0] g;
        logic [9:0]      a;
        g    = '0;
        g[0] = 10'd1;
        a    = 10'd1;
        for (int i = 0; i < P; i++) begin
            for (int k = P; k > 0; k--) g[k] = g[k-1] ^ gf_mul(g[k], a);
            g[0] = gf_mul(g[0], a);
            a    = gf_mul(a, 10'h002);
        end
        return g[P-1:0];
    endfunction

    localparam logic [P-1:0][9:0] G = gen_poly();

    state_t             state_q, state_d;
    logic [9:0]         cnt_q, cnt_d;
    logic [P-1:0][9:0]  par_q, par_d;
    logic               vld_q, vld_d;
    logic [9:0]         dat_q, dat_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               adv;
    logic               in_rdy;
    logic [9:0]         fb;

    assign adv    = !vld_q || bus.out_ready;
    assign in_rdy = (state_q == MSG) && adv;
    assign fb     = bus.in_data ^ par_q[P-1];

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = dat_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        unique case (state_q)
            MSG: begin
                if (bus.in_valid && in_rdy) begin
                    dat_d    = bus.in_data;
                    vld_d    = 1'b1;
                    sop_d    = (cnt_q == 10'd0);
                    eop_d    = 1'b0;
                    par_d[0] = gf_mul(fb, G[0]);
                    for (int j = 1; j < P; j++)
                        par_d[j] = par_q[j-1] ^ gf_mul(fb, G[j]);
                    if (cnt_q == 10'(K - 1)) begin
                        state_d = PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else if (adv) begin
                    vld_d = 1'b0;
                end
            end
            PAR: begin
                if (adv) begin
                    dat_d    = par_q[P-1];
                    vld_d    = 1'b1;
                    sop_d    = 1'b0;
                    eop_d    = (cnt_q == 10'(P - 1));
                    par_d[0] = '0;
                    for (int j = 1; j < P; j++) par_d[j] = par_q[j-1];
                    // Shifting zeros in leaves the LFSR clear for the next codeword.
                    if (cnt_q == 10'(P - 1)) begin
                        state_d = MSG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = MSG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MSG;
            cnt_q   <= '0;
            par_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

`ifdef RS_ENC_CW_CNT_EN
    logic [15:0] cw_cnt_q, cw_cnt_d;

    assign cw_cnt_d = (vld_q && bus.out_ready && eop_q) ? cw_cnt_q + 16'd1 : cw_cnt_q;
    assign cw_cnt   = cw_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cw_cnt_q <= '0;
        else        cw_cnt_q <= cw_cnt_d;
    end
`endif

endmodule

// File: tb/tb_rs_enc.sv
// Bench for rs_enc: randomized codewords against a polynomial-division model.
// Compile with RS_ENC_CW_CNT_EN defined to also exercise cw_cnt.
module tb_rs_enc;
    localparam int N = 544;
    localparam int K = 514;
    localparam int P = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_enc_if bus ();
`ifdef RS_ENC_CW_CNT_EN
    logic [15:0] cw_cnt;
`endif

    rs_enc #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RS_ENC_CW_CNT_EN
        ,
        .cw_cnt(cw_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    int gexp [0:1022];
    int glog [0:1023];
    logic [9:0] gpoly [0:P];

    logic [9:0] msgq [$];
    logic [9:0] expq [$];
    logic [9:0] outq [$];
    bit         sopq [$];
    bit         eopq [$];
    logic [9:0] ref_out [$];
    int run = 0;
    int maxrun = 0;

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        if (a == 0 || b == 0) return '0;
        return 10'(gexp[(glog[a] + glog[b]) % 1023]);
    endfunction

    // Remainder of m(x)*x^30 divided by g(x), by schoolbook long division.
    function automatic void model_encode(input int cw);
        logic [9:0] c [0:N-1];
        for (int d = 0; d < N; d++) c[d] = '0;
        for (int i = 0; i < K; i++) c[N-1-i] = msgq[cw*K+i];
        for (int d = N - 1; d >= P; d--) begin
            logic [9:0] q;
            q = c[d];
            if (q != 0)
                for (int k = 0; k <= P; k++) c[d-P+k] = c[d-P+k] ^ gmul(q, gpoly[k]);
        end
        for (int i = 0; i < K; i++) expq.push_back(msgq[cw*K+i]);
        for (int j = 0; j < P; j++) expq.push_back(c[P-1-j]);
    endfunction

    function automatic int first_diff();
        if (outq.size() != expq.size()) return -2;
        foreach (outq[i]) if (outq[i] !== expq[i]) return i;
        return -1;
    endfunction

    function automatic int bad_syndromes(input int base);
        int nbad;
        nbad = 0;
        for (int i = 0; i < P; i++) begin
            logic [9:0] s;
            s = '0;
            for (int j = 0; j < N; j++) s = gmul(s, 10'(gexp[i])) ^ outq[base+j];
            if (s != 0) nbad++;
        end
        return nbad;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            outq.push_back(bus.out_data);
            sopq.push_back(bus.out_sop);
            eopq.push_back(bus.out_eop);
        end
        if (bus.out_valid) run++;
        else run = 0;
        if (run > maxrun) maxrun = run;
    end

    task automatic run_stream(input bit stall, output bit timeout);
        int idx;
        int tgt;
        int cyc;
        idx = 0;
        cyc = 0;
        tgt = (msgq.size() / K) * N;
        outq.delete(); sopq.delete(); eopq.delete();
        expq.delete();
        for (int c = 0; c < msgq.size() / K; c++) model_encode(c);
        while (outq.size() < tgt && cyc < 20000) begin
            @(posedge clk); #1;
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = (idx < msgq.size());
            bus.in_data   = (idx < msgq.size()) ? msgq[idx] : '0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        timeout = (cyc >= 20000);
    endtask

    task automatic fill_random(input int ncw);
        msgq.delete();
        for (int i = 0; i < ncw * K; i++) msgq.push_back(10'($urandom_range(0, 1023)));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 10'd0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got d=%h s=%b e=%b want 0", bus.out_data, bus.out_sop, bus.out_eop);
        end
`ifdef RS_ENC_CW_CNT_EN
        checks++;
        if (cw_cnt !== 16'd0) begin errors++; $display("FAIL reset_cwcnt got %0d want 0", cw_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_inready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_zero();
        bit to;
        int nz;
        int nsop;
        int neop;
        msgq.delete();
        for (int i = 0; i < K; i++) msgq.push_back('0);
        run_stream(1'b0, to);
        checks++;
        if (to || outq.size() != N) begin
            errors++; $display("FAIL zero_len got %0d want %0d", outq.size(), N);
        end else begin
            nz = 0; nsop = 0; neop = 0;
            foreach (outq[i]) if (outq[i] !== 10'd0) nz++;
            foreach (sopq[i]) if (sopq[i]) nsop++;
            foreach (eopq[i]) if (eopq[i]) neop++;
            checks++;
            if (nz != 0) begin errors++; $display("FAIL zero_data got %0d nonzero want 0", nz); end
            checks++;
            if (!sopq[0] || nsop != 1) begin
                errors++; $display("FAIL zero_sop got first=%b count=%0d want 1/1", sopq[0], nsop);
            end
            checks++;
            if (!eopq[N-1] || neop != 1) begin
                errors++; $display("FAIL zero_eop got last=%b count=%0d want 1/1", eopq[N-1], neop);
            end
        end
    endtask

    task automatic test_impulse();
        bit to;
        int d;
        logic [9:0] g29;
        msgq.delete();
        for (int i = 0; i < K; i++) msgq.push_back((i == K - 1) ? 10'd1 : 10'd0);
        run_stream(1'b0, to);
        g29 = '0;
        for (int i = 0; i < P; i++) g29 = g29 ^ 10'(gexp[i]);
        d = first_diff();
        checks++;
        if (to || d != -1) begin
            errors++; $display("FAIL impulse_cw first bad index %0d want -1", d);
        end
        checks++;
        if (outq.size() < N || outq[K] !== g29) begin
            errors++;
            $display("FAIL impulse_g29 got %h want %h", (outq.size() > K) ? outq[K] : 10'h3ff, g29);
        end
    endtask

    task automatic test_random();
        bit to;
        int d;
        int nb;
        fill_random(1);
        run_stream(1'b0, to);
        d = first_diff();
        checks++;
        if (to || d != -1) begin
            errors++; $display("FAIL random_cw first bad index %0d want -1", d);
        end
        nb = (outq.size() == N) ? bad_syndromes(0) : P;
        checks++;
        if (nb != 0) begin
            errors++; $display("FAIL random_syndrome got %0d nonzero want 0", nb);
        end
        ref_out = outq;
    endtask

    task automatic test_stall();
        bit to;
        int nbad;
        run_stream(1'b1, to);
        nbad = 0;
        if (outq.size() != ref_out.size()) nbad = -1;
        else foreach (outq[i]) if (outq[i] !== ref_out[i]) nbad++;
        checks++;
        if (to || nbad != 0) begin
            errors++;
            $display("FAIL stall_cw got %0d diffs (len %0d) want 0 (len %0d)", nbad, outq.size(), ref_out.size());
        end
        checks++;
        if (outq.size() != N || !sopq[0] || !eopq[N-1]) begin
            errors++; $display("FAIL stall_marks got len=%0d want %0d with sop/eop", outq.size(), N);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        int nb;
`ifdef RS_ENC_CW_CNT_EN
        logic [15:0] c0;
        c0 = cw_cnt;
`endif
        fill_random(3);
        run = 0;
        maxrun = 0;
        run_stream(1'b0, to);
        d = first_diff();
        checks++;
        if (to || d != -1) begin
            errors++; $display("FAIL b2b_cw first bad index %0d want -1", d);
        end
        checks++;
        if (maxrun != 3 * N) begin
            errors++; $display("FAIL b2b_run got %0d want %0d", maxrun, 3 * N);
        end
        nb = (outq.size() == 3 * N) ? bad_syndromes(2 * N) : P;
        checks++;
        if (nb != 0) begin
            errors++; $display("FAIL b2b_syndrome got %0d nonzero want 0", nb);
        end
`ifdef RS_ENC_CW_CNT_EN
        checks++;
        if (cw_cnt !== 16'(c0 + 16'd3)) begin
            errors++; $display("FAIL b2b_cwcnt got %0d want %0d", cw_cnt, 16'(c0 + 16'd3));
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit to;
        int d;
        int idx;
        int cyc;
        fill_random(1);
        idx = 0;
        cyc = 0;
        while (idx < 100 && cyc < 1000) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = msgq[idx];
            @(negedge clk);
            if (bus.in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid);
        end
`ifdef RS_ENC_CW_CNT_EN
        checks++;
        if (cw_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cwcnt got %0d want 0", cw_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_inready got %b want 1", bus.in_ready);
        end
        fill_random(1);
        run_stream(1'b1, to);
        d = first_diff();
        checks++;
        if (to || d != -1) begin
            errors++; $display("FAIL midrst_cw first bad index %0d want -1", d);
        end
        checks++;
        if (outq.size() != N || !sopq[0] || !eopq[N-1]) begin
            errors++; $display("FAIL midrst_marks got len=%0d want %0d with sop/eop", outq.size(), N);
        end
    endtask

    initial begin
        int x;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        x = 1;
        for (int i = 0; i < 1023; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 'h400) != 0) x = x ^ 'h409;
        end
        for (int k = 0; k <= P; k++) gpoly[k] = (k == 0) ? 10'd1 : 10'd0;
        for (int i = 0; i < P; i++) begin
            for (int k = P; k > 0; k--) gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], 10'(gexp[i]));
            gpoly[0] = gmul(gpoly[0], 10'(gexp[i]));
        end

        test_reset();
        test_zero();
        test_impulse();
        test_random();
        test_stall();
        test_back_to_back();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
